// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding, default width
// and a small decode helper used by the top level.
package countdown_pkg;

   // Default width of count, load_value and the reload register.
   localparam int DEFAULT_WIDTH = 4;

   // Default prescale ratio when the prescaler build option is enabled.
   localparam int DEFAULT_PRESCALE = 10;

   // Timer control states. Encoding is fixed so that external checkers and
   // debug tooling can decode the state register directly.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   // busy is defined purely as "state is RUN".
   function automatic logic state_is_busy(input state_t s);
      return (s == RUN);
   endfunction

endpackage : countdown_pkg

// File: rtl/countdown_timer_prescale_tick.sv
// prescale_tick: modulo-PRESCALE counter with synchronous clear. Emits a
// single-cycle tick every PRESCALE cycles while not cleared. Only
// instantiated when COUNTDOWN_PRESCALE_EN is defined.
module prescale_tick #(
   parameter int PRESCALE = 10
) (
   input  logic clk,
   input  logic rst,   // synchronous, active-low
   input  logic clr,   // synchronous clear back to phase 0
   output logic tick
);

   // A one-bit counter is still needed for PRESCALE == 1 to keep widths legal.
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;

   // Phase counter: wraps at PRESCALE-1, restarts at 0 on reset or clear.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Tick on the last phase of each period.
   always_comb begin
      tick = (cnt_q == LAST);
   end

endmodule : prescale_tick

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause/resume and an optional
// auto-reload periodic mode. done pulses for one cycle at terminal count.
//
// Build option: COUNTDOWN_PRESCALE_EN adds a PRESCALE parameter; while in
// RUN the count then only moves on a prescale tick (one every PRESCALE
// cycles). Without it the count moves every RUN cycle.
//
// Per-edge priority: rst > load > stop > start > decrement.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
`ifdef COUNTDOWN_PRESCALE_EN
   ,
   parameter int PRESCALE = DEFAULT_PRESCALE
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             dec_en;

`ifdef COUNTDOWN_PRESCALE_EN
   logic pre_clr;

   // The prescaler restarts whenever the timer is not running, so an accepted
   // start (which always comes from IDLE or PAUSE) begins a fresh period and
   // the first decrement lands PRESCALE cycles after it. load and stop also
   // restart it.
   always_comb begin
      pre_clr = load || stop || (state_q != RUN);
   end

   prescale_tick #(
      .PRESCALE (PRESCALE)
   ) u_prescale_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .tick (dec_en)
   );
`else
   // Without the prescaler every RUN cycle is a decrement cycle.
   always_comb begin
      dec_en = 1'b1;
   end
`endif

   // State and datapath registers; reset clears everything including the
   // reload value, so a fresh load is needed after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   // Next-state and datapath decode in priority order load > stop > start >
   // decrement. In RUN the count is always >= 1, so the terminal tick is
   // "count == 1 on a decrement cycle" and the count can never underflow.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      if (load) begin
         // Load wins over everything and discards any terminal tick.
         count_d  = load_value;
         reload_d = load_value;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Starting from zero would finish instantly; it is ignored.
               if (start && (count_q != '0)) begin
                  state_d = RUN;
               end
            end

            RUN: begin
               if (stop) begin
                  state_d = PAUSE;
               end else if (dec_en) begin
                  if (count_q == ONE) begin
                     done_d = 1'b1;
                     if (auto_reload && (reload_q != '0)) begin
                        // Periodic mode jumps straight from 1 back to the
                        // reload value, so the period is reload_q cycles and
                        // 0 is never shown.
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = IDLE;
                     end
                  end else begin
                     count_d = count_q - ONE;
                  end
               end
            end

            PAUSE: begin
               // stop wins when both arrive: abort to IDLE, count retained.
               if (stop) begin
                  state_d = IDLE;
               end else if (start) begin
                  state_d = RUN;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers (busy decoded from registered state).
   always_comb begin
      count = count_q;
      busy  = state_is_busy(state_q);
      done  = done_q;
   end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (default build, no prescaler).
// A behavioural model tracks the timer with plain integers and flags and is
// stepped once per clock edge alongside the DUT.
module tb_countdown_timer;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] load_value;
   logic         start;
   logic         stop;
   logic         auto_reload;
   logic [W-1:0] count;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];

   // Reference model state.
   bit m_running;
   bit m_paused;
   int m_count;
   int m_reload;
   bit m_done;

   countdown_timer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_value  (load_value),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: applies one clock edge of the timer rules to integer state.
   task automatic model_step(input bit r, input bit l, input int lv,
                             input bit s, input bit p, input bit ar);
      m_done = 0;
      if (!r) begin
         m_running = 0; m_paused = 0; m_count = 0; m_reload = 0;
      end else if (l) begin
         m_count = lv; m_reload = lv; m_running = 0; m_paused = 0;
      end else if (m_running) begin
         if (p) begin
            m_running = 0; m_paused = 1;
         end else begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_done = 1;
               if (ar && m_reload != 0) m_count = m_reload;
               else m_running = 0;
            end
         end
      end else if (m_paused) begin
         if (p) m_paused = 0;
         else if (s) begin m_paused = 0; m_running = 1; end
      end else if (s && m_count != 0) begin
         m_running = 1;
      end
   endtask

   // Driver: apply inputs, take one edge, step model, compare 1 time unit later.
   task automatic cycle(input bit r, input bit l, input int lv,
                        input bit s, input bit p, input bit ar);
      rst = r; load = l; load_value = W'(lv); start = s; stop = p; auto_reload = ar;
      @(posedge clk);
      model_step(r, l, lv, s, p, ar);
      exp_q.push_back(W'(m_count));
      #1;
      check("count", 32'(count), 32'(exp_q.pop_front()));
      check("busy", 32'(busy), 32'(m_running));
      check("done", 32'(done), 32'(m_done));
   endtask

   task automatic idle_cycle();
      cycle(1, 0, 0, 0, 0, 0);
   endtask

   int dones;
   int waited;
   bit saw_zero;

   initial begin
      rst = 0; load = 0; load_value = '0; start = 0; stop = 0; auto_reload = 0;

      // Reset and quiet idle, then a lone start must be ignored.
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      check("rst_count", 32'(count), 0);
      check("rst_busy", 32'(busy), 0);
      for (int i = 0; i < 20; i++) idle_cycle();
      cycle(1, 0, 0, 1, 0, 0);
      check("start_zero_busy", 32'(busy), 0);
      check("start_zero_done", 32'(done), 0);

      // One-shot from 5.
      cycle(1, 1, 5, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      check("oneshot_first", 32'(count), 5);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         idle_cycle();
         if (done) dones++;
      end
      check("oneshot_dones", 32'(dones), 1);
      check("oneshot_end_count", 32'(count), 0);
      check("oneshot_end_busy", 32'(busy), 0);

      // Periodic from 3: four pulses in twelve cycles, never zero.
      cycle(1, 1, 3, 0, 0, 1);
      cycle(1, 0, 0, 1, 0, 1);
      dones = 0; saw_zero = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, 0, 0, 0, 1);
         if (done) dones++;
         if (count == 0) saw_zero = 1;
      end
      check("periodic_dones", 32'(dones), 4);
      check("periodic_zero", 32'(saw_zero), 0);
      cycle(1, 0, 0, 0, 1, 1);
      cycle(1, 0, 0, 0, 1, 1);

      // Load 9, pause at 4, hold, resume, finish.
      cycle(1, 1, 9, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      waited = 0;
      while (count != 4 && waited < 40) begin idle_cycle(); waited++; end
      check("wait_count4_timeout", 32'(waited < 40), 1);
      cycle(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) idle_cycle();
      check("pause_hold_count", 32'(count), 4);
      check("pause_hold_busy", 32'(busy), 0);
      cycle(1, 0, 0, 1, 0, 0);
      waited = 0;
      while (!done && waited < 40) begin idle_cycle(); waited++; end
      check("resume_done_timeout", 32'(waited < 40), 1);

      // Stop at count 1, start+stop aborts, then load mid-run.
      cycle(1, 1, 2, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      idle_cycle();
      cycle(1, 0, 0, 0, 1, 0);
      check("stop_at1_count", 32'(count), 1);
      check("stop_at1_done", 32'(done), 0);
      cycle(1, 0, 0, 1, 1, 0);
      cycle(1, 1, 4, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      idle_cycle();
      cycle(1, 1, 7, 0, 0, 0);
      check("load_midrun_count", 32'(count), 7);
      check("load_midrun_busy", 32'(busy), 0);

      // Reset mid-run, then start without load is ignored.
      cycle(1, 1, 8, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      idle_cycle();
      idle_cycle();
      cycle(0, 0, 0, 0, 0, 0);
      check("rst_mid_count", 32'(count), 0);
      cycle(1, 0, 0, 1, 0, 0);
      check("rst_mid_restart_busy", 32'(busy), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 59) != 0,
               $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 15)),
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got 0 expected 1");
      $fatal(1, "time limit");
   end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counting timer, the decrementing counterpart to the team's free-running up counter. Software or a controller loads a value, starts the timer, and receives a one-cycle done pulse at terminal count. It supports pause/resume and an auto-reload periodic mode. It sits beside the up counter as the timebase for timeouts and periodic events.

Parameters:
WIDTH, 4, width of count, load_value and reload register

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-low; sampled on posedge clk
load  input  1  load load_value into count and reload register
load_value  input  WIDTH  value captured when load=1
start  input  1  start from IDLE, or resume from PAUSE
stop  input  1  pause from RUN, or abort from PAUSE to IDLE
auto_reload  input  1  periodic mode; sampled at terminal tick
count  output  WIDTH  current count (registered)
busy  output  1  1 while state==RUN (decoded from registered state)
done  output  1  one-cycle pulse at terminal count (registered)

Behaviour:
- Reset (rst==0 at posedge): state IDLE, count=0, reload_reg=0, done=0, busy=0. Reset overrides all other inputs.
- States: IDLE, RUN, PAUSE. Priority per edge is rst > load > stop > start > decrement.
- load=1 in any state: count<=load_value, reload_reg<=load_value, state->IDLE, done=0. A pending terminal tick in that cycle is discarded.
- IDLE: start=1 with count!=0 goes to RUN. start=1 with count==0 is ignored and produces no done.
- RUN: each cycle count<=count-1 unless stop=1. stop=1 goes to PAUSE with count held. stop has priority over start and over the terminal tick.
- PAUSE: count held. start goes to RUN. stop goes to IDLE with count retained. start and stop together: stop wins, so the state goes to IDLE.
- Terminal tick is RUN with count==1 and no stop/load:
  - auto_reload=0: count<=0, done<=1, state->IDLE.
  - auto_reload=1 and reload_reg!=0: count<=reload_reg, done<=1, state stays RUN.
- Periodic mode never shows 0 on count; the period is exactly reload_reg cycles.
- Latency: start sampled at edge k with count N leads to done=1 in the cycle after edge k+N. busy deasserts on the same edge in one-shot mode.
- count never underflows: in RUN, count>=1 always. done is 0 in every cycle other than the cycle following a terminal tick.
- Reset mid-run clears reload_reg, so a new load is required before a restart.

Optional Feature:
COUNTDOWN_PRESCALE_EN
- Defined: adds parameter PRESCALE (default 10, >=1). In RUN, decrements and terminal ticks happen only on a prescale tick, one every PRESCALE cycles. The prescaler is cleared on rst, load, start and stop, so the first decrement comes PRESCALE cycles after start. stop/load still act immediately.
- Undefined: decrement every RUN cycle; no PRESCALE parameter and no prescaler logic.

Decomposition:
- Shared package/include countdown_pkg:
  - state encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10
  - default WIDTH constant
- One natural sub-module: prescale_tick, a modulo-PRESCALE counter with synchronous clear that emits a 1-cycle tick. It is instantiated only under COUNTDOWN_PRESCALE_EN.

Test Plan:
- rst=0 for 2 cycles, then release with all inputs 0 -> count=0, busy=0, done=0 held for 20 cycles; start alone is ignored.
- load 5, start, auto_reload=0 -> count 5,4,3,2,1,0; done=1 for exactly one cycle as count reaches 0; busy 1→0 on the same edge; state IDLE.
- load 3, auto_reload=1, start -> count 3,2,1,3,2,1,...; done pulses every 3 cycles (4 pulses in 12 cycles); count never shows 0.
- load 9, start, stop at count 4 -> count holds 4 and busy=0 for 10 cycles; start resumes with 3 on the next edge; done after 4 more cycles.
- RUN at count 1 with stop=1 -> PAUSE, count=1, no done. Then start+stop together -> IDLE. Then load 7 mid-run -> IDLE, count=7, no done.
- RUN at count 6, rst=0 one cycle -> next edge count=0, busy=0, done=0. A following start without load is ignored.
